mem_access: RTL and testbench

//  MEM-stage consumer of the EX/MEM pipeline register. Takes the registered EX result and memory op,

---
 rtl/mem_access_pkg.sv | 45 ++++
 rtl/mem_align.sv | 59 +++++
 rtl/mem_access.sv | 137 +++++++++++++
 tb/tb_mem_access.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mem_access_pkg
// Purpose  : Memory-op encodings, FSM states and op-classification helpers
// Revision : 1.0
// ============================================================================
package mem_access_pkg;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_t;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUS  = 1'b1
  } state_t;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

  // Byte ops can never be misaligned; halves need addr[0]=0, words addr[1:0]=0.
  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] lo);
    if ((op == MEM_LH) || (op == MEM_LHU) || (op == MEM_SH)) return lo[0];
    if ((op == MEM_LW) || (op == MEM_SW))                   return |lo;
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Byte-lane selection / store replication and load data alignment
// Revision : 1.0
// ============================================================================
module mem_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    sel   = 4'b1111;
    wdata = sdata;
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        sel   = 4'b0001 << addr_lo;
        wdata = {4{sdata[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        sel   = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{sdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_lo)
      2'd0:    lane_byte = rdata[7:0];
      2'd1:    lane_byte = rdata[15:8];
      2'd2:    lane_byte = rdata[23:16];
      default: lane_byte = rdata[31:24];
    endcase
    lane_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (op)
      MEM_LB:  load_data = {{24{lane_byte[7]}}, lane_byte};
      MEM_LBU: load_data = {24'd0, lane_byte};
      MEM_LH:  load_data = {{16{lane_half[15]}}, lane_half};
      MEM_LHU: load_data = {16'd0, lane_half};
      default: load_data = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM stage - req/ack data-bus transactions with timeout, load
//            alignment and registered write-back outputs
// Revision : 1.0
// ============================================================================
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_waddr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_wreg,
  input  logic [3:0]  mem_op,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_sdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        wb_wreg,
  output logic        mem_err
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [1:0]        addr_lo_q;
  logic [4:0]        waddr_q;

  logic [3:0]        cur_op;
  logic [1:0]        cur_lo;
  logic [3:0]        align_sel;
  logic [31:0]       align_wdata;
  logic [31:0]       load_data;
  logic              is_access;
  logic              bad_align;
  logic              timeout;

  // The aligner serves the incoming op in IDLE and the latched op in BUS.
  assign cur_op    = (state == S_BUS) ? op_q      : mem_op;
  assign cur_lo    = (state == S_BUS) ? addr_lo_q : mem_addr[1:0];
  assign is_access = is_load(mem_op) || is_store(mem_op);
  assign bad_align = misaligned(mem_op, mem_addr[1:0]);
  assign timeout   = (state == S_BUS) && !bus_ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign stallreq  = (state == S_IDLE) ? (is_access && !bad_align) : (!bus_ack && !timeout);

  mem_align u_align (
    .op        (cur_op),
    .addr_lo   (cur_lo),
    .sdata     (mem_sdata),
    .rdata     (bus_rdata),
    .sel       (align_sel),
    .wdata     (align_wdata),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= MEM_NOP;
      addr_lo_q <= 2'd0;
      waddr_q   <= 5'd0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= ZERO_WORD;
      bus_sel   <= 4'd0;
      bus_wdata <= ZERO_WORD;
      wb_waddr  <= 5'd0;
      wb_wdata  <= ZERO_WORD;
      wb_wreg   <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!is_access) begin
            wb_waddr <= mem_waddr;
            wb_wdata <= mem_wdata;
            wb_wreg  <= mem_wreg;
          end else if (bad_align) begin
            wb_wreg <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            state     <= S_BUS;
            cnt       <= '0;
            op_q      <= mem_op;
            addr_lo_q <= mem_addr[1:0];
            waddr_q   <= mem_waddr;
            bus_req   <= 1'b1;
            bus_we    <= is_store(mem_op);
            bus_addr  <= {mem_addr[31:2], 2'b00};
            bus_sel   <= align_sel;
            bus_wdata <= align_wdata;
            wb_wreg   <= 1'b0;
          end
        end
        S_BUS: begin
          if (bus_ack) begin
            bus_req <= 1'b0;
            state   <= S_IDLE;
            if (is_load(op_q)) begin
              wb_waddr <= waddr_q;
              wb_wdata <= load_data;
              wb_wreg  <= 1'b1;
            end else begin
              wb_wreg <= 1'b0;
            end
          end else if (timeout) begin
            bus_req <= 1'b0;
            state   <= S_IDLE;
            wb_wreg <= 1'b0;
            mem_err <= 1'b1;
          end else begin
            cnt     <= cnt + 1'b1;
            wb_wreg <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access
// Purpose  : Directed stimulus with a queued scoreboard on the write-back port
// Revision : 1.0
// ============================================================================
module tb_mem_access;
  import mem_access_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wreg;
  logic [3:0]  mem_op;
  logic [31:0] mem_addr;
  logic [31:0] mem_sdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_sel;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        wb_wreg;
  logic        mem_err;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        wreg;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT(TMO), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wreg  (mem_wreg),
    .mem_op    (mem_op),
    .mem_addr  (mem_addr),
    .mem_sdata (mem_sdata),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_sel   (bus_sel),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .stallreq  (stallreq),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .wb_wreg   (wb_wreg),
    .mem_err   (mem_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write-back or error pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && (wb_wreg === 1'b1 || mem_err === 1'b1)) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_wb: wreg=%b err=%b waddr=%0d wdata=0x%08h", wb_wreg, mem_err, wb_waddr, wb_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, e.wreg});
        chk("mem_err", {31'd0, mem_err}, {31'd0, e.err});
        if (e.wreg) begin
          chk("wb_waddr", {27'd0, wb_waddr}, {27'd0, e.waddr});
          chk("wb_wdata", wb_wdata, e.wdata);
        end
      end
    end
  end

  task automatic drive_idle();
    mem_op    = MEM_NOP;
    mem_wreg  = 1'b0;
    mem_waddr = 5'd31;
    mem_wdata = 32'hA5A5_A5A5;
    mem_addr  = 32'hFFFF_FFFF;
    mem_sdata = 32'h0BAD_0BAD;
  endtask

  task automatic push_exp(input logic [4:0] wa, input logic [31:0] wd, input logic wr, input logic er);
    exp_t e;
    e.waddr = wa; e.wdata = wd; e.wreg = wr; e.err = er;
    exp_q.push_back(e);
  endtask

  task automatic nop_op(input logic [4:0] wa, input logic [31:0] wd, input logic wr);
    @(negedge clk);
    mem_op = MEM_NOP; mem_waddr = wa; mem_wdata = wd; mem_wreg = wr; mem_addr = 32'h0;
    #1 chk("nop_stall", {31'd0, stallreq}, 32'd0);
    if (wr) push_exp(wa, wd, 1'b1, 1'b0);
    @(negedge clk);
    drive_idle();
    chk("nop_no_req", {31'd0, bus_req}, 32'd0);
  endtask

  // Aligned access with ack after `waits` cycles in BUS.
  task automatic bus_op(input logic [3:0] op, input logic [31:0] addr, input logic [4:0] wa,
                        input logic [31:0] sd, input logic [31:0] rd, input int waits,
                        input logic [3:0] x_sel, input logic [31:0] x_val);
    logic [31:0] mask;
    logic st;
    st = (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    mask = {{8{x_sel[3]}}, {8{x_sel[2]}}, {8{x_sel[1]}}, {8{x_sel[0]}}};
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_waddr = wa; mem_sdata = sd; mem_wreg = 1'b1;
    mem_wdata = 32'h5555_5555; bus_ack = 1'b0;
    #1 chk("issue_stall", {31'd0, stallreq}, 32'd1);
    if (!st) push_exp(wa, x_val, 1'b1, 1'b0);
    @(negedge clk);
    drive_idle();
    chk("bus_req", {31'd0, bus_req}, 32'd1);
    chk("bus_we", {31'd0, bus_we}, {31'd0, st});
    chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
    chk("bus_sel", {28'd0, bus_sel}, {28'd0, x_sel});
    if (st) chk("bus_wdata", bus_wdata & mask, x_val & mask);
    for (int i = 0; i < waits; i++) begin
      #1 chk("wait_stall", {31'd0, stallreq}, 32'd1);
      @(negedge clk);
    end
    bus_ack = 1'b1; bus_rdata = rd;
    #1 chk("ack_stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    chk("req_drop", {31'd0, bus_req}, 32'd0);
    if (st) chk("store_wreg", {31'd0, wb_wreg}, 32'd0);
  endtask

  task automatic misalign_op(input logic [3:0] op, input logic [31:0] addr);
    @(negedge clk);
    mem_op = op; mem_addr = addr; mem_waddr = 5'd9; mem_wreg = 1'b1; mem_sdata = 32'h1;
    #1 chk("mis_stall", {31'd0, stallreq}, 32'd0);
    push_exp(5'd9, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive_idle();
    chk("mis_no_req", {31'd0, bus_req}, 32'd0);
    @(negedge clk);
    chk("mis_pulse_end", {31'd0, mem_err}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
    drive_idle();
    #12;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_wb_wreg", {31'd0, wb_wreg}, 32'd0);
    chk("rst_mem_err", {31'd0, mem_err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    nop_op(5'd3, 32'h0000_1234, 1'b1);
    nop_op(5'd7, 32'hFFFF_0000, 1'b0);

    bus_op(MEM_LW,  32'h0000_0100, 5'd4,  32'h0, 32'hDEAD_BEEF, 3, 4'hF,    32'hDEAD_BEEF);
    bus_op(MEM_LB,  32'h0000_0103, 5'd5,  32'h0, 32'h80FF_FFFF, 0, 4'b1000, 32'hFFFF_FF80);
    bus_op(MEM_LBU, 32'h0000_0103, 5'd6,  32'h0, 32'h80FF_FFFF, 1, 4'b1000, 32'h0000_0080);
    bus_op(MEM_LH,  32'h0000_0102, 5'd8,  32'h0, 32'h80FF_1234, 0, 4'b1100, 32'hFFFF_80FF);
    bus_op(MEM_LHU, 32'h0000_0100, 5'd10, 32'h0, 32'h80FF_9234, 2, 4'b0011, 32'h0000_9234);
    bus_op(MEM_SH,  32'h0000_0202, 5'd11, 32'h0000_ABCD, 32'h0, 1, 4'b1100, 32'hABCD_0000);
    bus_op(MEM_SB,  32'h0000_0301, 5'd12, 32'h1234_5678, 32'h0, 0, 4'b0010, 32'h0000_7800);
    bus_op(MEM_SW,  32'h0000_0400, 5'd13, 32'hCAFE_F00D, 32'h0, 2, 4'hF,    32'hCAFE_F00D);

    misalign_op(MEM_LW, 32'h0000_0101);
    misalign_op(MEM_LH, 32'h0000_0103);
    misalign_op(MEM_SH, 32'h0000_0201);

    // Timeout: with TIMEOUT=4 the abort comes after four unacknowledged BUS cycles.
    @(negedge clk);
    mem_op = MEM_LW; mem_addr = 32'h0000_0500; mem_waddr = 5'd14; mem_wreg = 1'b1;
    push_exp(5'd14, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    drive_idle();
    for (int i = 0; i < TMO - 1; i++) begin
      #1 chk("tmo_wait_stall", {31'd0, stallreq}, 32'd1);
      @(negedge clk);
    end
    #1 chk("tmo_stall", {31'd0, stallreq}, 32'd0);
    @(negedge clk);
    chk("tmo_req_drop", {31'd0, bus_req}, 32'd0);

    nop_op(5'd2, 32'h0000_0042, 1'b1);

    // Asynchronous reset in the middle of a bus cycle.
    @(negedge clk);
    mem_op = MEM_LW; mem_addr = 32'h0000_0600; mem_waddr = 5'd15; mem_wreg = 1'b1;
    @(negedge clk);
    drive_idle();
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("async_rst_req", {31'd0, bus_req}, 32'd0);
    chk("async_rst_stall", {31'd0, stallreq}, 32'd0);
    chk("async_rst_wdata", wb_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nop_op(5'd1, 32'h0000_0099, 1'b1);

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
